snake_tile_renderer: RTL and testbench

- Pixel-colour stage directly downstream of the 640x480@60 Hz VGA timing generator.
- Holds a 40x30 tile map of 16x16-pixel tiles (snake game field). The MicroBlaze writes the map through a simple write port.
- Converts (h_cnt, v_cnt) into a tile lookup and a palette colour, and delays sync/blank so that they stay aligned with the colour output.
- Raises a sticky frame interrupt so the CPU can update the map during vertical blanking.

---
 rtl/snake_tile_renderer_if.sv | 38 +++
 rtl/snake_tile_renderer.sv | 157 +++++++++++++++
 tb/tb_snake_tile_renderer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/snake_tile_renderer_if.sv
// Video-timing, tile-map write and interrupt signals shared by the tile renderer and its driver.
// Latency: none (wiring only).
// Backpressure: none; the pixel stream is free-running and map writes are always accepted.
interface snake_tile_renderer_if;
  // Video timing in
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_sync;
  logic        v_sync;
  logic        blank;
  logic        frame_end;
  // Tile map write port
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  // Interrupt acknowledge
  logic        irq_ack;
  // Pixel and delayed timing out
  logic [11:0] rgb;
  logic        h_sync_o;
  logic        v_sync_o;
  logic        blank_o;
  logic        frame_irq;

  // Driver side: timing generator, CPU and display sink
  modport master (
    output h_cnt, v_cnt, h_sync, v_sync, blank, frame_end,
    output wr_en, wr_addr, wr_data, irq_ack,
    input  rgb, h_sync_o, v_sync_o, blank_o, frame_irq
  );

  // Renderer side
  modport slave (
    input  h_cnt, v_cnt, h_sync, v_sync, blank, frame_end,
    input  wr_en, wr_addr, wr_data, irq_ack,
    output rgb, h_sync_o, v_sync_o, blank_o, frame_irq
  );
endinterface

// File: rtl/snake_tile_renderer.sv
// Renders a 40x30 map of 16x16 tiles to RGB444, keeping sync/blank aligned; raises a sticky frame irq.
// Latency: 3 clk from (h_cnt, v_cnt, sync, blank) to (rgb, sync_o, blank_o); frame_irq 1 clk.
// Backpressure: none; one pixel per clock, map writes accepted every cycle. Option: GRID_LINES_EN.
module snake_tile_renderer #(
  parameter logic [11:0] COL_EMPTY = 12'h000,
  parameter logic [11:0] COL_BODY  = 12'h0F0,
  parameter logic [11:0] COL_HEAD  = 12'hFF0,
  parameter logic [11:0] COL_FOOD  = 12'hF00,
  parameter logic [11:0] COL_GRID  = 12'h333
) (
  input logic                 clk,
  input logic                 rst,
  snake_tile_renderer_if.slave bus
);

  localparam int TILES = 1200;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic blank;
  } side_t;

  localparam side_t SIDE_RST = '{h_sync: 1'b1, v_sync: 1'b0, blank: 1'b1};

  // Stage registers
  logic [10:0] s1_addr_d, s1_addr_q;
  side_t       s1_side_d, s1_side_q;
  side_t       s2_side_d, s2_side_q;
  logic [1:0]  s2_code_d, s2_code_q;
  logic [11:0] rgb_d, rgb_q;
  side_t       out_side_d, out_side_q;
  logic        frame_irq_d, frame_irq_q;

  logic [5:0]  col;
  logic [4:0]  row;
  logic        wr_ok;

  logic [1:0]  tile_mem [TILES];

  assign col   = bus.h_cnt[9:4];
  assign row   = bus.v_cnt[8:4];
  assign wr_ok = bus.wr_en && (bus.wr_addr < 11'd1200);

`ifdef GRID_LINES_EN
  // Only the "on a tile edge" fact of the low coordinate bits matters, so that
  // single bit travels down the pipe instead of both 4-bit fields.
  logic s1_grid_d, s1_grid_q;
  logic s2_grid_d, s2_grid_q;
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{bus.h_cnt[10], bus.v_cnt[9]};
`else
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{bus.h_cnt[10], bus.h_cnt[3:0], bus.v_cnt[9], bus.v_cnt[3:0]};
`endif

  // S0: tile index from pixel position (row*40 = row*32 + row*8); off-map pixels read tile 0
  always_comb begin
    s1_addr_d = '0;
    s1_side_d = '{h_sync: bus.h_sync, v_sync: bus.v_sync, blank: bus.blank};
    if ((col < 6'd40) && (row < 5'd30)) begin
      s1_addr_d = ({6'd0, row} << 5) + ({6'd0, row} << 3) + {5'd0, col};
    end
  end

  // S1: RAM read address is s1_addr_q; sideband just moves one stage on
  always_comb begin
    s2_code_d = tile_mem[s1_addr_q];
    s2_side_d = s1_side_q;
  end

`ifdef GRID_LINES_EN
  // Grid flag follows the pixel through S0 and S1
  always_comb begin
    s1_grid_d = (bus.h_cnt[3:0] == 4'd0) || (bus.v_cnt[3:0] == 4'd0);
    s2_grid_d = s1_grid_q;
  end
`endif

  // S2: palette lookup; blanking always wins so nothing is driven in the porches
  always_comb begin
    rgb_d = COL_EMPTY;
    unique case (s2_code_q)
      2'd0:    rgb_d = COL_EMPTY;
      2'd1:    rgb_d = COL_BODY;
      2'd2:    rgb_d = COL_HEAD;
      default: rgb_d = COL_FOOD;
    endcase
`ifdef GRID_LINES_EN
    if ((s2_code_q == 2'd0) && s2_grid_q) begin
      rgb_d = COL_GRID;
    end
`endif
    if (s2_side_q.blank) begin
      rgb_d = '0;
    end
    out_side_d = s2_side_q;
  end

  // Sticky frame interrupt: a new frame_end outranks a simultaneous acknowledge
  always_comb begin
    frame_irq_d = frame_irq_q;
    if (bus.frame_end) begin
      frame_irq_d = 1'b1;
    end else if (bus.irq_ack) begin
      frame_irq_d = 1'b0;
    end
  end

  // Pipeline and interrupt state; reset flushes every stage to the blanked idle values
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_addr_q   <= '0;
      s1_side_q   <= SIDE_RST;
      s2_side_q   <= SIDE_RST;
      rgb_q       <= '0;
      out_side_q  <= SIDE_RST;
      frame_irq_q <= 1'b0;
    end else begin
      s1_addr_q   <= s1_addr_d;
      s1_side_q   <= s1_side_d;
      s2_side_q   <= s2_side_d;
      rgb_q       <= rgb_d;
      out_side_q  <= out_side_d;
      frame_irq_q <= frame_irq_d;
    end
  end

`ifdef GRID_LINES_EN
  // Grid flag stages; reset value is irrelevant because blank is forced during reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_grid_q <= 1'b0;
      s2_grid_q <= 1'b0;
    end else begin
      s1_grid_q <= s1_grid_d;
      s2_grid_q <= s2_grid_d;
    end
  end
`endif

  // Tile RAM with registered read-first output. The read register has no reset so it
  // can live inside the RAM primitive; the reset blank flag masks it until refilled.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      tile_mem[bus.wr_addr] <= bus.wr_data;
    end
    s2_code_q <= s2_code_d;
  end

  assign bus.rgb       = rgb_q;
  assign bus.h_sync_o  = out_side_q.h_sync;
  assign bus.v_sync_o  = out_side_q.v_sync;
  assign bus.blank_o   = out_side_q.blank;
  assign bus.frame_irq = frame_irq_q;

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Self-checking bench for snake_tile_renderer: directed steps plus randomized pixels vs a tile-map model.
// Latency: expects outputs 3 clocks after inputs are applied; frame_irq 1 clock.
// Backpressure: none. Honours GRID_LINES_EN in the model when the design is built with it.
module tb_snake_tile_renderer;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [1:0]  tmodel [1200];
  logic [14:0] expq [$];

  snake_tile_renderer_if bus_if ();

  snake_tile_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: colour of a pixel from the tile map using plain arithmetic
  function automatic logic [11:0] ref_rgb(input int h, input int v, input bit bl);
    int col, row, idx;
    logic [11:0] c;
    col = (h / 16) % 64;
    row = (v / 16) % 32;
    idx = (col >= 40 || row >= 30) ? 0 : row * 40 + col;
    case (tmodel[idx])
      2'd0: c = 12'h000;
      2'd1: c = 12'h0F0;
      2'd2: c = 12'hFF0;
      default: c = 12'hF00;
    endcase
`ifdef GRID_LINES_EN
    if (tmodel[idx] == 2'd0 && ((h % 16) == 0 || (v % 16) == 0)) c = 12'h333;
`endif
    if (bl) c = 12'h000;
    return c;
  endfunction

  task automatic drive_pix(input int h, input int v, input bit hs, input bit vs, input bit bl);
    bus_if.h_cnt  = h[10:0];
    bus_if.v_cnt  = v[9:0];
    bus_if.h_sync = hs;
    bus_if.v_sync = vs;
    bus_if.blank  = bl;
  endtask

  // One cycle of streamed pixels; compares the pixel applied two calls earlier
  task automatic stream(input string tag, input int h, input int v, input bit hs, input bit vs, input bit bl);
    logic [14:0] e;
    drive_pix(h, v, hs, vs, bl);
    expq.push_back({ref_rgb(h, v, bl), hs, vs, bl});
    tick();
    if (expq.size() == 3) begin
      e = expq.pop_front();
      chk(tag, {17'd0, bus_if.rgb, bus_if.h_sync_o, bus_if.v_sync_o, bus_if.blank_o}, {17'd0, e});
    end
  endtask

  task automatic write_tile(input int a, input logic [1:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a[10:0];
    bus_if.wr_data = d;
    tick();
    bus_if.wr_en = 1'b0;
    if (a < 1200) tmodel[a] = d;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    drive_pix(0, 0, 1'b1, 1'b0, 1'b1);
    bus_if.frame_end = 1'b0;
    bus_if.irq_ack   = 1'b0;
    bus_if.wr_en     = 1'b0;
    bus_if.wr_addr   = '0;
    bus_if.wr_data   = '0;

    // Reset with arbitrary inputs toggling
    for (int i = 0; i < 4; i++) begin
      drive_pix($urandom_range(0, 2047), $urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom));
      bus_if.frame_end = 1'($urandom);
      bus_if.irq_ack   = 1'($urandom);
      tick();
    end
    chk("rst_rgb", {20'd0, bus_if.rgb}, 32'h000);
    chk("rst_hs", {31'd0, bus_if.h_sync_o}, 32'd1);
    chk("rst_vs", {31'd0, bus_if.v_sync_o}, 32'd0);
    chk("rst_blank", {31'd0, bus_if.blank_o}, 32'd1);
    chk("rst_irq", {31'd0, bus_if.frame_irq}, 32'd0);

    rst = 1'b1;
    bus_if.frame_end = 1'b0;
    bus_if.irq_ack   = 1'b0;
    drive_pix(0, 0, 1'b1, 1'b0, 1'b1);

    // Fill the whole map with random codes
    for (int a = 0; a < 1200; a++) write_tile(a, 2'($urandom));
    write_tile(0, 2'd2);
    write_tile(1199, 2'd3);
    write_tile(1, 2'd0);
    // Out-of-range writes must leave the map untouched
    write_tile(1200, 2'd1);
    write_tile(2047, 2'd1);

    // First tile: exactly 3 cycles, still blank after 2
    drive_pix(0, 0, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    drive_pix(5, 7, 1'b1, 1'b1, 1'b0);
    tick();
    drive_pix(0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("head_early", {20'd0, bus_if.rgb}, 32'h000);
    tick();
    chk("head_tile", {20'd0, bus_if.rgb}, 32'hFF0);

    // Last tile
    drive_pix(639, 479, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("last_tile", {20'd0, bus_if.rgb}, 32'hF00);

    // Origin after out-of-range writes
    drive_pix(0, 0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("oor_write", {20'd0, bus_if.rgb}, 32'hFF0);

    // Read-first: write to tile 0 lands on the same edge the first pixel reads it
    drive_pix(0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 11'd0;
    bus_if.wr_data = 2'd1;
    tick();
    bus_if.wr_en = 1'b0;
    tmodel[0] = 2'd1;
    tick();
    chk("read_first_old", {20'd0, bus_if.rgb}, 32'hFF0);
    tick();
    chk("read_first_new", {20'd0, bus_if.rgb}, 32'h0F0);

    // Empty tile on a tile boundary
    drive_pix(16, 5, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
`ifdef GRID_LINES_EN
    chk("grid_empty", {20'd0, bus_if.rgb}, 32'h333);
`else
    chk("empty_tile", {20'd0, bus_if.rgb}, 32'h000);
`endif

    // Full line sweep with h_sync and blank toggling
    expq.delete();
    for (int h = 0; h < 800; h++) begin
      stream("line", h, 200, !(h >= 656 && h < 752), 1'b1, h >= 640);
    end

    // Random pixels across the whole counter range
    expq.delete();
    for (int i = 0; i < 1500; i++) begin
      stream("rand", $urandom_range(0, 2047), $urandom_range(0, 1023), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    // Frame interrupt
    bus_if.frame_end = 1'b1;
    bus_if.irq_ack   = 1'b1;
    tick();
    chk("irq_set_wins", {31'd0, bus_if.frame_irq}, 32'd1);
    bus_if.frame_end = 1'b0;
    bus_if.irq_ack   = 1'b0;
    tick();
    chk("irq_sticky", {31'd0, bus_if.frame_irq}, 32'd1);
    bus_if.irq_ack = 1'b1;
    tick();
    chk("irq_ack", {31'd0, bus_if.frame_irq}, 32'd0);
    bus_if.irq_ack   = 1'b0;
    bus_if.frame_end = 1'b1;
    tick();
    chk("irq_set", {31'd0, bus_if.frame_irq}, 32'd1);
    bus_if.frame_end = 1'b0;

    // Reset mid-frame flushes the pipe, output resumes 3 cycles after release
    drive_pix(300, 100, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_rgb", {20'd0, bus_if.rgb}, 32'h000);
    chk("midrst_side", {29'd0, bus_if.h_sync_o, bus_if.v_sync_o, bus_if.blank_o}, 32'b101);
    chk("midrst_irq", {31'd0, bus_if.frame_irq}, 32'd0);
    rst = 1'b1;
    drive_pix(5, 7, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    chk("midrst_hold", {31'd0, bus_if.blank_o}, 32'd1);
    tick();
    chk("midrst_resume", {17'd0, bus_if.rgb, bus_if.h_sync_o, bus_if.v_sync_o, bus_if.blank_o},
        {17'd0, 12'h0F0, 3'b010});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
